// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the hazard/halt control slice.
package core_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ECALL_ARG_REG = 5'd17;
    localparam int DEFAULT_HALT_CODE = 10;
endpackage

// File: rtl/hazard_halt_unit_if.sv
// hazard_halt_unit_if: ID/EX/MEM hazard inputs and pipeline stall controls.
interface hazard_halt_unit_if #(parameter int XLEN = 32);
    import core_pkg::*;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_is_ecall;
    logic [XLEN-1:0]  id_x17_val;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             ex_write_enable;
    logic [REG_W-1:0] mem_rd;
    logic             mem_mem_read;
    logic             ex_flush;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             is_halted;
    logic [31:0]      stall_count;
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_ecall, id_x17_val,
               ex_rd, ex_mem_read, ex_write_enable, mem_rd, mem_mem_read, ex_flush,
        input  pc_write, if_id_write, id_ex_bubble, is_halted, stall_count
    );
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_ecall, id_x17_val,
               ex_rd, ex_mem_read, ex_write_enable, mem_rd, mem_mem_read, ex_flush,
        output pc_write, if_id_write, id_ex_bubble, is_halted, stall_count
    );
endinterface

// File: rtl/hazard_halt_unit_hazard_detect.sv
// hazard_detect: combinational load-use and ecall-operand hazard detection.
module hazard_detect
    import core_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_is_ecall,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_write_enable,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_mem_read,
    output logic             lu,
    output logic             eh
);
    assign lu = ex_mem_read && ex_rd != '0 &&
                ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    // ecall reads x17 in ID, so an in-flight producer of x17 must land first
    assign eh = id_is_ecall && ((ex_write_enable && ex_rd == ECALL_ARG_REG) ||
                                (mem_mem_read && mem_rd == ECALL_ARG_REG));
endmodule

// File: rtl/hazard_halt_unit.sv
// hazard_halt_unit: pipeline stall control and ecall-driven halt sequencing.
module hazard_halt_unit
    import core_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int HALT_CODE    = DEFAULT_HALT_CODE
) (
    input logic clk,
    input logic reset,
    hazard_halt_unit_if.slave bus
);
    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] stall_cnt;
    logic        halted;
    logic        lu, eh, run, stall, accept;

    hazard_detect u_detect (
        .id_rs1(bus.id_rs1), .id_rs2(bus.id_rs2),
        .id_use_rs1(bus.id_use_rs1), .id_use_rs2(bus.id_use_rs2),
        .id_is_ecall(bus.id_is_ecall),
        .ex_rd(bus.ex_rd), .ex_mem_read(bus.ex_mem_read), .ex_write_enable(bus.ex_write_enable),
        .mem_rd(bus.mem_rd), .mem_mem_read(bus.mem_mem_read),
        .lu(lu), .eh(eh)
    );

    assign run    = state == RUN;
    assign stall  = (lu || eh) && !bus.ex_flush && run;
    assign accept = run && bus.id_is_ecall && !stall && !bus.ex_flush &&
                    bus.id_x17_val == XLEN'(HALT_CODE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (accept) begin
            state_n = DRAIN;
            cnt_n   = 4'(DRAIN_CYCLES);
        end else if (state == DRAIN) begin
            cnt_n   = cnt - 4'd1;
            state_n = cnt == 4'd1 ? HALTED : DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            cnt       <= '0;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            halted <= halted || state_n == HALTED;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.pc_write     = run && !stall;
    assign bus.if_id_write  = run && !stall;
    assign bus.id_ex_bubble = !run || stall;
    assign bus.is_halted    = halted;
    assign bus.stall_count  = stall_cnt;
endmodule

// File: tb/tb_hazard_halt_unit.sv
// tb_hazard_halt_unit: directed scenario checks for hazard_halt_unit.
module tb_hazard_halt_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_halt_unit_if #(.XLEN(32)) bus ();
    hazard_halt_unit #(.XLEN(32), .DRAIN_CYCLES(3), .HALT_CODE(10)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    task automatic clear_inputs;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
        bus.id_is_ecall = 0; bus.id_x17_val = '0; bus.ex_rd = '0; bus.ex_mem_read = 0;
        bus.ex_write_enable = 0; bus.mem_rd = '0; bus.mem_mem_read = 0; bus.ex_flush = 0;
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL reset_pc_write got %b want 1", bus.pc_write); end
        checks++; if (bus.if_id_write !== 1'b1) begin errors++; $display("FAIL reset_if_id_write got %b want 1", bus.if_id_write); end
        checks++; if (bus.id_ex_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b want 0", bus.id_ex_bubble); end
        checks++; if (bus.is_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus.is_halted); end
        checks++; if (bus.stall_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.stall_count); end
    endtask

    task automatic test_load_use;
        do_reset();
        bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_use_rs1 = 1; bus.id_rs1 = 5;
        #1;
        checks++; if ({bus.pc_write, bus.if_id_write, bus.id_ex_bubble} !== 3'b001) begin errors++; $display("FAIL lu_stall got %b want 001", {bus.pc_write, bus.if_id_write, bus.id_ex_bubble}); end
        step();
        clear_inputs();
        #1;
        checks++; if (bus.stall_count !== 32'd1) begin errors++; $display("FAIL lu_count got %0d want 1", bus.stall_count); end
        checks++; if ({bus.pc_write, bus.id_ex_bubble} !== 2'b10) begin errors++; $display("FAIL lu_release got %b want 10", {bus.pc_write, bus.id_ex_bubble}); end
        bus.ex_mem_read = 1; bus.ex_rd = 0; bus.id_use_rs1 = 1; bus.id_rs1 = 0;
        bus.id_use_rs2 = 1; bus.id_rs2 = 0;
        #1;
        checks++; if ({bus.pc_write, bus.id_ex_bubble} !== 2'b10) begin errors++; $display("FAIL lu_rd0 got %b want 10", {bus.pc_write, bus.id_ex_bubble}); end
        bus.ex_rd = 9; bus.id_use_rs1 = 0; bus.id_rs1 = 9; bus.id_rs2 = 9;
        #1;
        checks++; if (bus.id_ex_bubble !== 1'b1) begin errors++; $display("FAIL lu_rs2 got %b want 1", bus.id_ex_bubble); end
        bus.id_use_rs2 = 0;
        #1;
        checks++; if (bus.id_ex_bubble !== 1'b0) begin errors++; $display("FAIL lu_unused got %b want 0", bus.id_ex_bubble); end
        step();
        checks++; if (bus.stall_count !== 32'd1) begin errors++; $display("FAIL lu_rd0_count got %0d want 1", bus.stall_count); end
    endtask

    task automatic test_ecall_hazard;
        do_reset();
        bus.id_is_ecall = 1; bus.id_x17_val = 10; bus.ex_write_enable = 1; bus.ex_rd = 17;
        #1;
        checks++; if ({bus.pc_write, bus.id_ex_bubble} !== 2'b01) begin errors++; $display("FAIL eh_ex got %b want 01", {bus.pc_write, bus.id_ex_bubble}); end
        step();
        bus.ex_write_enable = 0; bus.ex_rd = 0; bus.mem_mem_read = 1; bus.mem_rd = 17;
        #1;
        checks++; if ({bus.pc_write, bus.id_ex_bubble} !== 2'b01) begin errors++; $display("FAIL eh_mem got %b want 01", {bus.pc_write, bus.id_ex_bubble}); end
        step();
        clear_inputs();
        #1;
        checks++; if (bus.stall_count !== 32'd2) begin errors++; $display("FAIL eh_count got %0d want 2", bus.stall_count); end
        checks++; if (bus.is_halted !== 1'b0 || bus.pc_write !== 1'b1) begin errors++; $display("FAIL eh_no_halt got halted=%b pc=%b want 0 1", bus.is_halted, bus.pc_write); end
    endtask

    task automatic test_halt;
        do_reset();
        bus.id_is_ecall = 1; bus.id_x17_val = 10; bus.ex_write_enable = 1; bus.ex_rd = 17;
        #1;
        checks++; if (bus.id_ex_bubble !== 1'b1) begin errors++; $display("FAIL halt_pre_stall got %b want 1", bus.id_ex_bubble); end
        step();
        bus.ex_write_enable = 0; bus.ex_rd = 0;
        #1;
        checks++; if ({bus.pc_write, bus.id_ex_bubble} !== 2'b10) begin errors++; $display("FAIL halt_accept_T got %b want 10", {bus.pc_write, bus.id_ex_bubble}); end
        step();
        clear_inputs();
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++; if ({bus.pc_write, bus.if_id_write, bus.id_ex_bubble, bus.is_halted} !== 4'b0010) begin errors++; $display("FAIL halt_drain_%0d got %b want 0010", k, {bus.pc_write, bus.if_id_write, bus.id_ex_bubble, bus.is_halted}); end
            step();
        end
        bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_use_rs1 = 1; bus.id_rs1 = 5;
        for (int k = 0; k < 21; k++) begin
            #1;
            checks++; if ({bus.pc_write, bus.id_ex_bubble, bus.is_halted} !== 3'b011) begin errors++; $display("FAIL halt_hold_%0d got %b want 011", k, {bus.pc_write, bus.id_ex_bubble, bus.is_halted}); end
            step();
        end
        checks++; if (bus.stall_count !== 32'd1) begin errors++; $display("FAIL halt_count got %0d want 1", bus.stall_count); end
    endtask

    task automatic test_flush;
        do_reset();
        bus.id_is_ecall = 1; bus.id_x17_val = 10; bus.ex_flush = 1;
        #1;
        checks++; if ({bus.pc_write, bus.id_ex_bubble} !== 2'b10) begin errors++; $display("FAIL flush_ecall got %b want 10", {bus.pc_write, bus.id_ex_bubble}); end
        step();
        clear_inputs();
        #1;
        checks++; if ({bus.pc_write, bus.id_ex_bubble} !== 2'b10) begin errors++; $display("FAIL flush_no_drain got %b want 10", {bus.pc_write, bus.id_ex_bubble}); end
        bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_use_rs1 = 1; bus.id_rs1 = 5; bus.ex_flush = 1;
        #1;
        checks++; if ({bus.pc_write, bus.id_ex_bubble} !== 2'b10) begin errors++; $display("FAIL flush_lu got %b want 10", {bus.pc_write, bus.id_ex_bubble}); end
        step();
        clear_inputs();
        step();
        checks++; if (bus.stall_count !== 32'd0 || bus.is_halted !== 1'b0) begin errors++; $display("FAIL flush_state got count=%0d halted=%b want 0 0", bus.stall_count, bus.is_halted); end
    endtask

    task automatic test_non_halt;
        do_reset();
        bus.id_is_ecall = 1; bus.id_x17_val = 5;
        #1;
        checks++; if ({bus.pc_write, bus.id_ex_bubble} !== 2'b10) begin errors++; $display("FAIL nonhalt_T got %b want 10", {bus.pc_write, bus.id_ex_bubble}); end
        step();
        clear_inputs();
        for (int k = 0; k < 5; k++) step();
        checks++; if ({bus.pc_write, bus.is_halted} !== 2'b10) begin errors++; $display("FAIL nonhalt_after got %b want 10", {bus.pc_write, bus.is_halted}); end
    endtask

    task automatic test_reset_mid_drain;
        do_reset();
        bus.ex_mem_read = 1; bus.ex_rd = 3; bus.id_use_rs2 = 1; bus.id_rs2 = 3;
        step();
        clear_inputs();
        bus.id_is_ecall = 1; bus.id_x17_val = 10;
        step();
        clear_inputs();
        step();
        #1;
        checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL drain_T2 got %b want 0", bus.pc_write); end
        reset = 1;
        step();
        reset = 0;
        #1;
        checks++; if ({bus.pc_write, bus.is_halted} !== 2'b10 || bus.stall_count !== 32'd0) begin errors++; $display("FAIL mid_drain_reset got pc=%b halted=%b count=%0d want 1 0 0", bus.pc_write, bus.is_halted, bus.stall_count); end
        for (int k = 0; k < 5; k++) step();
        checks++; if ({bus.pc_write, bus.is_halted} !== 2'b10) begin errors++; $display("FAIL after_reset_run got %b want 10", {bus.pc_write, bus.is_halted}); end
    endtask

    task automatic test_saturation;
        do_reset();
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        bus.ex_mem_read = 1; bus.ex_rd = 7; bus.id_use_rs1 = 1; bus.id_rs1 = 7;
        step();
        step();
        clear_inputs();
        #1;
        checks++; if (bus.stall_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_count got %h want ffffffff", bus.stall_count); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_ecall_hazard();
        test_halt();
        test_flush();
        test_non_halt();
        test_reset_mid_drain();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_halt_unit.md
Name: hazard_halt_unit

Overview:
Pipeline-side consumer of the decoded control bundle (mem_read, write_enable, is_ecall) for the 5-stage RISC-V core. It detects load-use and ecall-operand hazards in ID and drives the PC, IF/ID and ID/EX stall controls. It runs the halt sequence: when an `ecall` with x17 == HALT_CODE is accepted, the pipeline drains and `is_halted` asserts.

Parameters:
XLEN, 32, register data width
DRAIN_CYCLES, 3, cycles the accepted ecall needs to retire (EX, MEM, WB); legal range 1..15
HALT_CODE, 10, x17 value that requests a halt

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high; sampled on rising edge of clk
id_rs1  input  5  ID rs1 index
id_rs2  input  5  ID rs2 index
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
id_is_ecall  input  1  ID instruction is ecall (from decode)
id_x17_val  input  XLEN  x17 as read or forwarded in ID
ex_rd  input  5  EX destination
ex_mem_read  input  1  EX instruction is a load
ex_write_enable  input  1  EX writes the register file
mem_rd  input  5  MEM destination
mem_mem_read  input  1  MEM instruction is a load
ex_flush  input  1  EX branch/jump redirect; ID instruction is wrong-path
pc_write  output  1  PC may update
if_id_write  output  1  IF/ID may load
id_ex_bubble  output  1  ID/EX loads a NOP control bundle
is_halted  output  1  sticky halt flag
stall_count  output  32  saturating count of hazard-stall cycles

Behaviour:
- Reset values: state RUN, drain counter 0, is_halted 0, stall_count 0. Combinational outputs follow state, so the reset cycle drives pc_write 1, if_id_write 1 and id_ex_bubble 0.
- Load-use hazard (lu) = ex_mem_read && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)).
- Ecall hazard (eh) = id_is_ecall && ((ex_write_enable && ex_rd == 17) || (mem_mem_read && mem_rd == 17)).
- stall = (lu || eh) && !ex_flush && state == RUN.
- In RUN:
  - pc_write = if_id_write = !stall.
  - id_ex_bubble = stall.
  - ex_flush suppresses the stall; squashing is handled elsewhere.
- Halt accept, cycle T: state RUN && id_is_ecall && !stall && !ex_flush && id_x17_val == HALT_CODE. The next state is DRAIN and the counter loads DRAIN_CYCLES.
- The accepted ecall itself enters ID/EX normally at the edge ending cycle T, so id_ex_bubble = 0 in T.
- A non-halt ecall, where x17 != HALT_CODE, passes through as a normal instruction.
- DRAIN:
  - Outputs: pc_write 0, if_id_write 0, id_ex_bubble 1.
  - Each cycle the counter decrements.
  - When the counter equals 1, the next state is HALTED. DRAIN therefore occupies cycles T+1..T+DRAIN_CYCLES.
- HALTED:
  - Outputs: pc_write 0, if_id_write 0, id_ex_bubble 1, is_halted 1 (registered, rising at the start of T+DRAIN_CYCLES+1).
  - Stays in HALTED until reset. All hazard inputs are ignored.
- stall_count: increments by 1 on each edge where stall = 1 in RUN and saturates at 0xFFFFFFFF. DRAIN and HALTED cycles are not counted.
- Simultaneous events:
  - ex_flush and a halt-qualifying ecall in the same cycle: no halt (wrong-path).
  - eh and a halt-qualifying ecall: stall first; the halt is accepted on the first non-stalled cycle.
  - rd == 0 never causes a stall.
- Reset mid-DRAIN or in HALTED: return to RUN next edge, counter 0, is_halted 0, stall_count 0.

Decomposition:
- Shared package (core_pkg) holds:
  - state enum {RUN, DRAIN, HALTED}
  - ECALL_ARG_REG = 17
  - default HALT_CODE
  - register index width 5
- Sub-module hazard_detect: purely combinational lu/eh computation. The top level keeps the FSM, drain counter and stall_count.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_use_rs1=1, id_rs1=5 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count 0->1. Same with ex_rd=0 -> no stall.
- Ecall operand hazard: id_is_ecall=1, ex_write_enable=1, ex_rd=17 -> stall. Next cycle mem_mem_read=1, mem_rd=17 -> stall again; stall_count=2.
- Halt: id_is_ecall=1, id_x17_val=10, no hazard at T -> DRAIN during T+1..T+3; is_halted=1 from T+4 and held 20 more cycles with pc_write=0.
- Flush priority: id_is_ecall=1, x17=10, ex_flush=1 -> no halt, no stall, state stays RUN. Also lu=1 with ex_flush=1 -> no stall.
- Non-halt ecall: x17=5 -> passes, no bubble, is_halted stays 0.
- Reset mid-DRAIN at T+2 -> RUN next edge, pc_write=1, is_halted=0, stall_count=0. Force stall_count to 0xFFFFFFFF and stall -> stays saturated.
